// File: rtl/ucnt_pkg.sv
// Shared constants and helpers for the ucnt up/down counter and its bench.
package ucnt_pkg;

  localparam logic UCNT_DIR_UP   = 1'b1;
  localparam logic UCNT_DIR_DOWN = 1'b0;

  // Load values above the terminal count settle on the terminal count.
  function automatic longint unsigned ucnt_clamp(input longint unsigned val,
                                                 input longint unsigned max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/ucnt_next.sv
// Combinational next-count and wrap-flag generator for ucnt.
// Saturating comparators are only built when UCNT_SAT_EN is defined.
module ucnt_next
  import ucnt_pkg::*;
#(
  parameter int unsigned       WIDTH = 8,
  parameter longint unsigned   MAX   = 255
) (
  input  logic [WIDTH-1:0] out,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);

  logic [WIDTH:0] cur;
  logic [WIDTH:0] up;
  logic [WIDTH:0] dn;
  logic           hold;

`ifdef UCNT_SAT_EN
  assign hold = sat;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign hold = 1'b0;
`endif

  // One extra bit lets MAX == 2**WIDTH-1 overflow and zero underflow be seen.
  always_comb begin
    cur  = {1'b0, out};
    up   = cur + (WIDTH+1)'(1);
    dn   = cur - (WIDTH+1)'(1);
    next = out;
    wrap = 1'b0;
    if (dir == UCNT_DIR_UP) begin
      if (up > MAX_X) begin
        if (!hold) begin
          next = '0;
          wrap = 1'b1;
        end
      end else begin
        next = up[WIDTH-1:0];
      end
    end else begin
      if (dn[WIDTH]) begin
        if (!hold) begin
          next = MAX_X[WIDTH-1:0];
          wrap = 1'b1;
        end
      end else begin
        next = dn[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/ucnt.sv
// Parametrised up/down counter with load, registered wrap pulse and an
// optional saturating mode (UCNT_SAT_EN).
module ucnt
  import ucnt_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX     = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             ucnt_clk,
  input  logic             ucnt_rst,
  input  logic             ucnt_en,
  input  logic             ucnt_dir,
  input  logic             ucnt_load,
  input  logic [WIDTH-1:0] ucnt_load_val,
  input  logic             ucnt_sat,
  output logic [WIDTH-1:0] ucnt_out,
  output logic             ucnt_wrap,
  output logic             ucnt_zero
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("ucnt: WIDTH must be in 1..32");
  end
  if (MAX < 1) begin : g_bad_max_lo
    $error("ucnt: MAX must be >= 1");
  end
  if (MAX > (64'd1 << WIDTH) - 64'd1) begin : g_bad_max_hi
    $error("ucnt: MAX must be < 2**WIDTH");
  end
  if (RST_VAL > MAX) begin : g_bad_rst
    $error("ucnt: RST_VAL must be <= MAX");
  end

  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic [WIDTH-1:0] load_clamped;

  ucnt_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_next (
    .out  (ucnt_out),
    .dir  (ucnt_dir),
    .sat  (ucnt_sat),
    .next (step_val),
    .wrap (step_wrap)
  );

  assign load_clamped = WIDTH'(ucnt_clamp(64'(ucnt_load_val), MAX));

  always_ff @(posedge ucnt_clk) begin
    if (!ucnt_rst) begin
      ucnt_out  <= WIDTH'(RST_VAL);
      ucnt_wrap <= 1'b0;
    end else if (ucnt_load) begin
      ucnt_out  <= load_clamped;
      ucnt_wrap <= 1'b0;
    end else if (ucnt_en) begin
      ucnt_out  <= step_val;
      ucnt_wrap <= step_wrap;
    end else begin
      ucnt_wrap <= 1'b0;
    end
  end

  assign ucnt_zero = (ucnt_out == '0);

endmodule

// File: tb/tb_ucnt.sv
// Self-checking bench for ucnt as a decade counter (WIDTH=4, MAX=9).
// Expected saturate results depend on whether UCNT_SAT_EN is defined.
module tb_ucnt;
  import ucnt_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int          MAXV  = 9;
  localparam int          MODV  = MAXV + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             sat = 1'b0;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             zero;

  int checks = 0;
  int errors = 0;
  int m_out  = 0;
  int m_wrap = 0;

  ucnt #(
    .WIDTH   (WIDTH),
    .MAX     (64'(MAXV)),
    .RST_VAL (64'd0)
  ) dut (
    .ucnt_clk      (clk),
    .ucnt_rst      (rst),
    .ucnt_en       (en),
    .ucnt_dir      (dir),
    .ucnt_load     (load),
    .ucnt_load_val (load_val),
    .ucnt_sat      (sat),
    .ucnt_out      (out),
    .ucnt_wrap     (wrap),
    .ucnt_zero     (zero)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and advances the reference model on the edge.
  task automatic cycle(input logic r, input logic e, input logic d,
                       input logic l, input int lv, input logic s);
    int  nxt;
    bit  sat_on;
    @(negedge clk);
    rst = r; en = e; dir = d; load = l; load_val = WIDTH'(lv); sat = s;
    @(posedge clk);
`ifdef UCNT_SAT_EN
    sat_on = s;
`else
    sat_on = 1'b0;
`endif
    if (!r) begin
      m_out = 0; m_wrap = 0;
    end else if (l) begin
      m_out = int'(ucnt_clamp(64'(lv), 64'(MAXV))); m_wrap = 0;
    end else if (e) begin
      nxt = d ? m_out + 1 : m_out - 1;
      if (nxt < 0 || nxt > MAXV) begin
        if (sat_on) m_wrap = 0;
        else begin m_out = (nxt + MODV) % MODV; m_wrap = 1; end
      end else begin
        m_out = nxt; m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      checks++;
      if ({out, wrap, zero} !== {4'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset[%0d] out=%0d wrap=%b zero=%b expected out=0 wrap=0 zero=1", i, out, wrap, zero);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      checks++;
      if ({out, wrap, zero} !== {4'(i), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_release[%0d] out=%0d wrap=%b zero=%b expected out=%0d wrap=0 zero=0", i, out, wrap, zero, i);
      end
    end
  endtask

  task automatic test_up_wrap();
    int exp_o[4] = '{8, 9, 0, 1};
    int exp_w[4] = '{0, 0, 1, 0};
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      checks++;
      if ({out, wrap, zero} !== {4'(exp_o[i]), 1'(exp_w[i]), exp_o[i] == 0}) begin
        errors++;
        $display("FAIL up_wrap[%0d] out=%0d wrap=%b zero=%b expected out=%0d wrap=%0d", i, out, wrap, zero, exp_o[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_down_wrap_clamp();
    int exp_o[6] = '{3, 2, 1, 0, 9, 8};
    int exp_w[6] = '{0, 0, 0, 0, 1, 0};
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    checks++;
    if (out !== 4'd4) begin
      errors++;
      $display("FAIL load4 out=%0d expected 4", out);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      checks++;
      if ({out, wrap, zero} !== {4'(exp_o[i]), 1'(exp_w[i]), exp_o[i] == 0}) begin
        errors++;
        $display("FAIL down_wrap[%0d] out=%0d wrap=%b zero=%b expected out=%0d wrap=%0d", i, out, wrap, zero, exp_o[i], exp_w[i]);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 15, 1'b0);
    checks++;
    if ({out, wrap} !== {4'd9, 1'b0}) begin
      errors++;
      $display("FAIL load_clamp out=%0d wrap=%b expected out=9 wrap=0", out, wrap);
    end
  endtask

  task automatic test_load_precedence();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 5, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    checks++;
    if ({out, wrap} !== {4'd2, 1'b0}) begin
      errors++;
      $display("FAIL load_over_en out=%0d wrap=%b expected out=2 wrap=0", out, wrap);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    if ({out, wrap} !== {4'd3, 1'b0}) begin
      errors++;
      $display("FAIL after_load out=%0d wrap=%b expected out=3 wrap=0", out, wrap);
    end
    // A load on the edge that would wrap suppresses the pulse.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 9, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    checks++;
    if ({out, wrap} !== {4'd3, 1'b0}) begin
      errors++;
      $display("FAIL load_at_wrap out=%0d wrap=%b expected out=3 wrap=0", out, wrap);
    end
  endtask

  task automatic test_saturate();
`ifdef UCNT_SAT_EN
    int exp_o[4] = '{9, 9, 9, 9};
    int exp_w[4] = '{0, 0, 0, 0};
    int exp_d[2] = '{0, 0};
    int exp_dw[2] = '{0, 0};
`else
    int exp_o[4] = '{9, 0, 1, 2};
    int exp_w[4] = '{0, 1, 0, 0};
    int exp_d[2] = '{0, 9};
    int exp_dw[2] = '{0, 1};
`endif
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
      checks++;
      if ({out, wrap} !== {4'(exp_o[i]), 1'(exp_w[i])}) begin
        errors++;
        $display("FAIL sat_up[%0d] out=%0d wrap=%b expected out=%0d wrap=%0d", i, out, wrap, exp_o[i], exp_w[i]);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
      checks++;
      if ({out, wrap} !== {4'(exp_d[i]), 1'(exp_dw[i])}) begin
        errors++;
        $display("FAIL sat_down[%0d] out=%0d wrap=%b expected out=%0d wrap=%0d", i, out, wrap, exp_d[i], exp_dw[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 9, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    checks++;
    if ({out, wrap, zero} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset out=%0d wrap=%b zero=%b expected out=0 wrap=0 zero=1", out, wrap, zero);
    end
  endtask

  task automatic test_random();
    logic r, e, l;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(19) != 0);
      l = ($urandom_range(7) == 0);
      e = ($urandom_range(3) != 0);
      cycle(r, e, 1'($urandom), l, int'($urandom_range(15)), 1'($urandom));
      checks++;
      if ({out, wrap, zero} !== {4'(m_out), 1'(m_wrap), m_out == 0}) begin
        errors++;
        $display("FAIL random[%0d] out=%0d wrap=%b zero=%b expected out=%0d wrap=%0d", i, out, wrap, zero, m_out, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap_clamp();
    test_load_precedence();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucnt.md
# ucnt

Parametrised synchronous up/down counter. It is the successor to the fixed 4-bit enable counter and adds:
- configurable width and modulus;
- direction control and parallel load;
- a registered wrap pulse;
- an optional saturating mode.

It sits beside the quiz/lab datapaths as a general event and cycle counter, e.g. a decade counter for display digits or a prescaler tap.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (1..32)
- MAX, 2**WIDTH-1, terminal count. Sequence is 0..MAX, so the modulus is MAX+1. Legal range 1..2**WIDTH-1.
- RST_VAL, 0, value loaded on reset; must be ≤ MAX

Ports (clock and reset first):
- ucnt_clk  in  1  clock; all logic on rising edge
- ucnt_rst  in  1  reset, synchronous, active-low (0 = reset)
- ucnt_en  in  1  count enable; one step per cycle while high
- ucnt_dir  in  1  1 = count up, 0 = count down
- ucnt_load  in  1  parallel load strobe
- ucnt_load_val  in  WIDTH  value for load
- ucnt_sat  in  1  1 = saturate at the ends, 0 = wrap (only honoured with UCNT_SAT_EN)
- ucnt_out  out  WIDTH  registered count
- ucnt_wrap  out  1  registered one-cycle pulse on wrap-around
- ucnt_zero  out  1  combinational, ucnt_out == 0

## Operation
Priority per rising edge, highest first:
- **Reset** (ucnt_rst == 0): ucnt_out ← RST_VAL, ucnt_wrap ← 0.
- **Load** (ucnt_load == 1):
  - ucnt_out ← min(ucnt_load_val, MAX); values above MAX clamp to MAX.
  - ucnt_wrap ← 0.
  - Load overrides en and dir in the same cycle.
- **Count** (ucnt_en == 1):
  - Up, out < MAX: out+1. Up, out == MAX: → 0, ucnt_wrap ← 1.
  - Down, out > 0: out−1. Down, out == 0: → MAX, ucnt_wrap ← 1.
  - In saturate mode the ends hold instead of wrapping: up at MAX stays MAX, down at 0 stays 0, and ucnt_wrap ← 0.
- **Idle**: ucnt_out holds, ucnt_wrap ← 0.

Rules that apply in every case:
- ucnt_wrap is never high for two consecutive cycles unless a wrap occurs on each of those edges.
- Arithmetic is done at WIDTH+1 bits internally, so no silent truncation occurs when MAX == 2**WIDTH-1.
- ucnt_dir and ucnt_sat are sampled only on cycles with en=1 and load=0. They may change freely every cycle.

## Timing
- Latency: ucnt_out reflects an en/load/rst sampled at edge N immediately after edge N, i.e. one cycle.
- ucnt_wrap is aligned with the wrapped value. In the cycle where ucnt_out first shows 0 (up) or MAX (down), ucnt_wrap is 1.
- Reset and load take effect on a mid-count cycle with no residual state. A wrap pulse scheduled for that edge is suppressed.
- ucnt_zero has no register stage and follows ucnt_out with zero latency.
- Reset values: ucnt_out = RST_VAL, ucnt_wrap = 0, ucnt_zero = (RST_VAL == 0).
- No initial-block reliance: outputs are undefined until the first reset edge.

## Configuration
- Macro: UCNT_SAT_EN.
- Defined: the saturating comparator logic is built and ucnt_sat selects wrap (0) or saturate (1).
- Undefined: the ucnt_sat port still exists but is ignored. The counter always wraps, and the saturate logic is not synthesised.

## Structure
- Shared package ucnt_pkg holds:
  - the direction constants UCNT_DIR_UP = 1'b1 and UCNT_DIR_DOWN = 1'b0;
  - a localparam-style function ucnt_clamp(val, max) used by both the load path and the bench.
- Elaboration-time checks (generate/error):
  - MAX ≥ 1;
  - MAX < 2**WIDTH;
  - RST_VAL ≤ MAX.
- One sub-module is natural: ucnt_next, a combinational next-state/wrap-flag generator taking out, dir, sat, and MAX. The top holds only the registers and the priority mux.

## Test plan
Bench configuration is WIDTH=4, MAX=9, RST_VAL=0 (decade counter):
- Reset: hold ucnt_rst=0 for 2 cycles with en=1 → out=0, wrap=0, zero=1. Release → out counts 1, 2, 3 on successive edges.
- Up wrap: en=1, dir=1 from 7 → out 8, 9, 0, 1. wrap=1 only in the cycle out=0.
- Down wrap and load clamp:
  - load_val=4, then dir=0 for 6 cycles → 4, 3, 2, 1, 0, 9, 8, with wrap=1 only on the 9.
  - Load load_val=15 → out=9.
- Load precedence: at out=5, assert load=1 with load_val=2 and en=1 → next out=2 and wrap=0. Next cycle with en=1, dir=1 → out=3.
- Saturate (UCNT_SAT_EN defined):
  - sat=1, up from 8 for 4 cycles → 9, 9, 9, 9, wrap always 0.
  - Down from 1 → 0, 0.
  - The same stimulus without the macro → 9, 0, 1, 2.
- Mid-count reset: ucnt_rst=0 on the edge where out=9 with en=1, dir=1 → out=0 and wrap=0, because the pending wrap is suppressed.
